// File: rtl/membus_arb.sv
// membus_arb: two-master arbiter onto a shared single-beat slave bus with
// address decode, ROM write protection for the CPU port and a sticky error flag.
// Ports:
//   clk, n_reset        clock, synchronous active-low reset
//   m0_*                debugger request port (valid/adr/wdata/wstrb in, ready/rdata out)
//   m1_*                CPU request port, same shape as m0
//   s_adr/s_wdata/s_wstrb, ram_sel/mmio_sel/rom_sel   shared slave bus outputs
//   s_rdata             OR-combined slave read data, valid the cycle after a select
//   owner               port of the in-flight or last transaction (0 = m0, 1 = m1)
//   err, err_clr        sticky error flag and its clear
module membus_arb #(
  parameter bit DBG_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [31:0] s_adr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  output logic        ram_sel,
  output logic        mmio_sel,
  output logic        rom_sel,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        err,
  input  logic        err_clr
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned PW = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            err_q, err_d;
  logic            unmap_q, unmap_d;
  logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
  logic            m0_ready_q, m0_ready_d;
  logic            m1_ready_q, m1_ready_d;
  logic [AW-1:0]   s_adr_q, s_adr_d;
  logic [DW-1:0]   s_wdata_q, s_wdata_d;
  logic [SW-1:0]   s_wstrb_q, s_wstrb_d;
  logic            ram_sel_q, ram_sel_d;
  logic            mmio_sel_q, mmio_sel_d;
  logic            rom_sel_q, rom_sel_d;

  // Arbitration and decode of the candidate request in IDLE.
  logic            any_valid, win;
  logic [AW-1:0]   win_adr;
  logic [DW-1:0]   win_wdata;
  logic [SW-1:0]   win_wstrb;
  logic [PW-1:0]   win_page;
  logic            hit_ram, hit_mmio, hit_rom, unmapped, rom_wp;

  always_comb begin
    any_valid = m0_valid | m1_valid;
    // Contention: debugger priority, or hand the bus to the non-owner.
    if (m0_valid && m1_valid) win = DBG_PRIO ? 1'b0 : ~owner_q;
    else                      win = m1_valid;
    win_adr   = win ? m1_adr   : m0_adr;
    win_wdata = win ? m1_wdata : m0_wdata;
    win_wstrb = win ? m1_wstrb : m0_wstrb;
    win_page  = win_adr[AW-1:AW-PW];
    hit_ram   = (win_page == PW'(16'h0000));
    hit_mmio  = (win_page == PW'(16'h0001));
    hit_rom   = (win_page == PW'(16'h0002));
    unmapped  = ~(hit_ram | hit_mmio | hit_rom);
    // Only the CPU is write-protected from ROM.
    rom_wp    = win & hit_rom & (|win_wstrb);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b1;
      err_q      <= 1'b0;
      unmap_q    <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      s_adr_q    <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      ram_sel_q  <= 1'b0;
      mmio_sel_q <= 1'b0;
      rom_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      unmap_q    <= unmap_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      s_adr_q    <= s_adr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      ram_sel_q  <= ram_sel_d;
      mmio_sel_q <= mmio_sel_d;
      rom_sel_q  <= rom_sel_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register next values; bus outputs are loaded on IDLE->ISSUE so
  // they are visible exactly during ISSUE, readys are loaded on ISSUE->RESP.
  always_comb begin
    owner_d    = owner_q;
    err_d      = err_clr ? 1'b0 : err_q;
    unmap_d    = unmap_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    s_adr_d    = '0;
    s_wdata_d  = '0;
    s_wstrb_d  = '0;
    ram_sel_d  = 1'b0;
    mmio_sel_d = 1'b0;
    rom_sel_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d    = win;
          unmap_d    = unmapped;
          s_adr_d    = win_adr;
          s_wdata_d  = win_wdata;
          s_wstrb_d  = rom_wp ? SW'(0) : win_wstrb;
          ram_sel_d  = hit_ram;
          mmio_sel_d = hit_mmio;
          rom_sel_d  = hit_rom;
          // Set wins over a coincident clear.
          if (unmapped || rom_wp) err_d = 1'b1;
        end
      end
      ISSUE: begin
        m0_ready_d = ~owner_q;
        m1_ready_d = owner_q;
      end
      RESP: begin
        // Unmapped accesses return zero regardless of the bus.
        if (owner_q) m1_rdata_d = unmap_q ? DW'(0) : s_rdata;
        else         m0_rdata_d = unmap_q ? DW'(0) : s_rdata;
      end
      default: ;
    endcase
  end

  assign m0_ready = m0_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_ready = m1_ready_q;
  assign m1_rdata = m1_rdata_q;
  assign s_adr    = s_adr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign ram_sel  = ram_sel_q;
  assign mmio_sel = mmio_sel_q;
  assign rom_sel  = rom_sel_q;
  assign owner    = owner_q;
  assign err      = err_q;

endmodule
